// File: rtl/spi_sd_master_pkg.sv
// Shared types and defaults for the SD/MMC SPI master used by MSX cartridge mappers.
package spi_sd_master_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t IDLE = 2'd0;
  localparam spi_state_t LOW  = 2'd1;
  localparam spi_state_t HIGH = 2'd2;
  localparam spi_state_t DONE = 2'd3;

  // Half-period minus one: ~400 kHz init clock, and clk/2 for data transfer.
  localparam logic [7:0] SPI_SLOW_DIV_DEFAULT = 8'd63;
  localparam logic [7:0] SPI_FAST_DIV_DEFAULT = 8'd0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: latches a divider on load, counts while enabled and flags the
// last cycle of each half-period (count equals latched divider).
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == div_q);

endmodule

// File: rtl/spi_sd_master.sv
// SPI mode-0 byte master for SD cards with register-driven chip selects, slow/fast
// clock select, ready handshake and a sticky overrun flag.
module spi_sd_master
  import spi_sd_master_pkg::*;
#(
  parameter int               NUM_CS   = 2,
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] SLOW_DIV = DIV_W'(SPI_SLOW_DIV_DEFAULT),
  parameter logic [DIV_W-1:0] FAST_DIV = DIV_W'(SPI_FAST_DIV_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx,
  input  logic              rx,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              ready,
  output logic              overrun,
  input  logic              cs_wr,
  input  logic [NUM_CS-1:0] cs_val,
  input  logic              speed,
  output logic [NUM_CS-1:0] spi_ss_n,
  output logic              spi_clk,
  output logic              spi_do,
  input  logic              spi_di
);

  spi_state_t        state;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic              rx_bit;
  logic              speed_q;
  logic              pend_vld;
  logic [NUM_CS-1:0] pend_cs;
  logic              pend_speed;
  logic              tc;

  logic             req;
  logic             idle;
  logic             speed_eff;
  logic [DIV_W-1:0] div_sel;

  assign req   = tx | rx;
  assign idle  = (state == IDLE);
  assign ready = idle;
  // A chip-select write in the same idle cycle as a request already governs its speed.
  assign speed_eff = cs_wr ? speed : speed_q;
  assign div_sel   = speed_eff ? FAST_DIV : SLOW_DIV;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .load  (idle & req),
    .en    ((state == LOW) || (state == HIGH)),
    .div   (div_sel),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= 8'hFF;
      bit_cnt    <= 3'd0;
      rx_bit     <= 1'b1;
      spi_clk    <= 1'b0;
      spi_do     <= 1'b1;
      spi_ss_n   <= '1;
      dout       <= 8'hFF;
      overrun    <= 1'b0;
      speed_q    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_cs    <= '0;
      pend_speed <= 1'b0;
    end else begin
      if (cs_wr)
        overrun <= 1'b0;
      if (req && !idle)
        overrun <= 1'b1;
      if (cs_wr && (state == LOW || state == HIGH)) begin
        pend_vld   <= 1'b1;
        pend_cs    <= cs_val;
        pend_speed <= speed;
      end

      case (state)
        IDLE: begin
          if (cs_wr) begin
            spi_ss_n <= ~cs_val;
            speed_q  <= speed;
          end
          if (req) begin
            shift   <= tx ? din : 8'hFF;
            spi_do  <= tx ? din[7] : 1'b1;
            bit_cnt <= 3'd0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (tc) begin
            spi_clk <= 1'b1;
            rx_bit  <= spi_di;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (tc) begin
            shift   <= {shift[6:0], rx_bit};
            bit_cnt <= bit_cnt + 3'd1;
            spi_clk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
            end else begin
              spi_do <= shift[6];
              state  <= LOW;
            end
          end
        end
        default: begin
          dout     <= shift;
          state    <= IDLE;
          pend_vld <= 1'b0;
          // A write landing in this very cycle is newer than any held one.
          if (cs_wr) begin
            spi_ss_n <= ~cs_val;
            speed_q  <= speed;
          end else if (pend_vld) begin
            spi_ss_n <= ~pend_cs;
            speed_q  <= pend_speed;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sd_master.sv
// Randomised and directed checks of spi_sd_master against a transaction-level model.
module tb_spi_sd_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx = 1'b0;
  logic       rx = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cs_wr = 1'b0;
  logic [1:0] cs_val = 2'b00;
  logic       speed = 1'b0;
  wire  [7:0] dout;
  wire        ready;
  wire        overrun;
  wire  [1:0] spi_ss_n;
  wire        spi_clk;
  wire        spi_do;
  wire        spi_di;

  int tests = 0;
  int fails = 0;

  // Model of what software expects to see.
  bit         m_speed = 1'b0;
  logic [1:0] m_ss_n = 2'b11;
  bit         m_ovr = 1'b0;

  // Slave side: loopback or a shift register presenting MSB first, advancing on falling SCK.
  logic       loop_en = 1'b0;
  logic [7:0] slave_sh = 8'hFF;
  bit         mosi_q[$];

  assign spi_di = loop_en ? spi_do : slave_sh[7];

  always #5 clk = ~clk;

  always @(negedge spi_clk) slave_sh = {slave_sh[6:0], 1'b1};
  always @(posedge spi_clk) mosi_q.push_back(spi_do);

  spi_sd_master dut (
    .clk      (clk),
    .reset    (reset),
    .tx       (tx),
    .rx       (rx),
    .din      (din),
    .dout     (dout),
    .ready    (ready),
    .overrun  (overrun),
    .cs_wr    (cs_wr),
    .cs_val   (cs_val),
    .speed    (speed),
    .spi_ss_n (spi_ss_n),
    .spi_clk  (spi_clk),
    .spi_do   (spi_do),
    .spi_di   (spi_di)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int xfer_len(input bit s);
    return 16 * ((s ? 0 : 63) + 1) + 1;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_ss_n"}, spi_ss_n, 2'b11);
    chk({tag, "_sclk"}, spi_clk, 1'b0);
    chk({tag, "_mosi"}, spi_do, 1'b1);
    chk({tag, "_dout"}, dout, 8'hFF);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_ovr"}, overrun, 1'b0);
  endtask

  task automatic do_cs(input logic [1:0] v, input bit s);
    @(negedge clk);
    cs_wr = 1'b1; cs_val = v; speed = s;
    @(negedge clk);
    cs_wr = 1'b0;
    m_ss_n = ~v; m_speed = s; m_ovr = 1'b0;
    chk("cs_ss_n", spi_ss_n, m_ss_n);
    chk("cs_ovr_clear", overrun, 1'b0);
  endtask

  // One byte transfer; optional mid-flight extra request, chip-select write, or reset,
  // and optional chip-select/speed write in the same cycle as the request.
  task automatic xfer(input bit t, input bit r, input logic [7:0] d, input logic [7:0] sl,
                      input bit lp, input int ovr_at, input int cs_at, input logic [1:0] cs_v,
                      input int rst_at, input bit same_cs, input bit same_sp);
    int n;
    int lim;
    int ss_changes;
    logic [1:0] ss_before;
    logic [7:0] mosi;
    logic [7:0] exp_dout;

    loop_en = lp;
    slave_sh = sl;
    mosi_q.delete();
    ss_before = spi_ss_n;
    @(negedge clk);
    tx = t; rx = r; din = d;
    if (same_cs) begin
      cs_wr = 1'b1; cs_val = cs_v; speed = same_sp;
      m_ss_n = ~cs_v; m_speed = same_sp; m_ovr = 1'b0;
      ss_before = ~cs_v;
    end
    lim = xfer_len(m_speed);
    @(negedge clk);
    tx = 1'b0; rx = 1'b0; cs_wr = 1'b0;
    chk("ready_drop", ready, 1'b0);
    n = 0;
    ss_changes = 0;
    while (!ready && n < lim + 5) begin
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        m_ss_n = 2'b11; m_speed = 1'b0; m_ovr = 1'b0;
        check_reset_state("abort");
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      tx = (n == ovr_at);
      cs_wr = (n == cs_at);
      cs_val = cs_v;
      speed = m_speed;
      @(negedge clk);
      tx = 1'b0; cs_wr = 1'b0;
      n++;
      if (ovr_at >= 0 && n == ovr_at + 1) begin
        m_ovr = 1'b1;
        chk("overrun_set", overrun, 1'b1);
      end
      if (!ready && spi_ss_n !== ss_before) ss_changes++;
    end
    if (cs_at >= 0) m_ss_n = ~cs_v;
    chk("xfer_len", n, lim);
    exp_dout = lp ? (t ? d : 8'hFF) : sl;
    chk("dout", dout, exp_dout);
    chk("ss_held_busy", ss_changes, 0);
    chk("ss_after", spi_ss_n, m_ss_n);
    chk("ovr_after", overrun, m_ovr);
    chk("mosi_count", mosi_q.size(), 8);
    mosi = 8'h00;
    foreach (mosi_q[i]) if (i < 8) mosi[7 - i] = mosi_q[i];
    chk("mosi_bits", mosi, t ? d : 8'hFF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("idle");

    // Fast loopback byte.
    do_cs(2'b01, 1'b1);
    xfer(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, -1, -1, 2'b00, -1, 1'b0, 1'b0);

    // Slow receive from the slave.
    do_cs(2'b01, 1'b0);
    xfer(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, -1, -1, 2'b00, -1, 1'b0, 1'b0);

    // Request while busy sets a sticky overrun, cleared only by a chip-select write.
    xfer(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 3, -1, 2'b00, -1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", overrun, 1'b1);
    do_cs(2'b01, 1'b1);

    // Chip-select write held until the end of the byte.
    xfer(1'b1, 1'b0, 8'hC3, 8'h00, 1'b1, -1, 5, 2'b00, -1, 1'b0, 1'b0);

    // tx and rx together: tx wins.
    do_cs(2'b01, 1'b1);
    xfer(1'b1, 1'b1, 8'h40, 8'h99, 1'b0, -1, -1, 2'b00, -1, 1'b0, 1'b0);

    // Same-cycle chip-select/speed write and request: new speed used.
    do_cs(2'b01, 1'b0);
    xfer(1'b1, 1'b0, 8'h6E, 8'h00, 1'b1, -1, -1, 2'b10, -1, 1'b1, 1'b1);

    // Reset at bit 4, then a normal transfer.
    xfer(1'b1, 1'b0, 8'hF0, 8'h00, 1'b1, -1, -1, 2'b00, 8, 1'b0, 1'b0);
    do_cs(2'b01, 1'b1);
    xfer(1'b1, 1'b0, 8'h81, 8'h00, 1'b1, -1, -1, 2'b00, -1, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      bit s, t, r, lp;
      logic [1:0] cv;
      s  = ($urandom_range(0, 3) != 0);
      cv = 2'($urandom_range(0, 3));
      t  = 1'($urandom_range(0, 1));
      r  = t ? 1'($urandom_range(0, 1)) : 1'b1;
      lp = 1'($urandom_range(0, 1));
      do_cs(cv, s);
      xfer(t, r, 8'($urandom), 8'($urandom), lp, -1, -1, 2'b00, -1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
